tl_req_arbiter: RTL

Round-robin arbiter and sequencer that shares the single CPU-side TileLink master command port among N requesters. It accepts level-held read/write requests, grants one at a time, and issues a one-cycle command pulse to the master only when the master reports idle. It then tracks completion: `m_trans_over` for writes, `m_rdata_v` for reads, or a timeout. Finally it returns a done pulse, read data and an error flag to the granted requester. It sits between the requester blocks and the master's `cpu_*` command inputs.

---
 rtl/tl_arb_pkg.sv | 28 ++
 rtl/tl_req_arbiter_rr_pick.sv | 32 +++
 rtl/tl_req_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tl_arb_pkg.sv
// ------------------------------------------------------------------
// tl_arb_pkg : shared types and constants for the request arbiter
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package tl_arb_pkg;

  localparam int TL_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // "byte" is a reserved word, hence byte_en
  typedef struct packed {
    logic                 wr;
    logic [3:0]           byte_en;
    logic [3:0]           addr;
    logic [TL_DATA_W-1:0] wdata;
  } arb_cmd_t;

endpackage

`default_nettype wire

// File: rtl/tl_req_arbiter_rr_pick.sv
// ------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search starts after last_i
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_o && req_i[i] && (((int'(last_i) + k) % N) == i)) begin
          gnt_o[i] = 1'b1;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_req_arbiter.sv
// ------------------------------------------------------------------
// tl_req_arbiter : shares the TileLink master command port among N requesters
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tl_req_arbiter
  import tl_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           rq_valid,
  input  logic [N-1:0]           rq_wr,
  input  logic [4*N-1:0]         rq_byte,
  input  logic [4*N-1:0]         rq_addr,
  input  logic [TL_DATA_W*N-1:0] rq_wdata,
  output logic [N-1:0]           rq_done,
  output logic                   rq_err,
  output logic [TL_DATA_W-1:0]   rq_rdata,
  output logic                   m_wr,
  output logic                   m_rd,
  output logic [3:0]             m_byte,
  output logic [3:0]             m_addr,
  output logic [TL_DATA_W-1:0]   m_wdata,
  input  logic                   m_rdata_v,
  input  logic [TL_DATA_W-1:0]   m_rdata,
  input  logic                   m_trans_over
);

  localparam int c_IW = $clog2(N);
  localparam int c_TW = $clog2(TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [c_IW-1:0]      idx_q, idx_d;
  logic [c_IW-1:0]      last_q, last_d;
  arb_cmd_t             cmd_q, cmd_d;
  logic [c_TW-1:0]      timer_q, timer_d;
  logic                 m_wr_q, m_wr_d;
  logic                 m_rd_q, m_rd_d;
  logic [N-1:0]         rq_done_q, rq_done_d;
  logic                 rq_err_q, rq_err_d;
  logic [TL_DATA_W-1:0] rq_rdata_q, rq_rdata_d;

  logic [N-1:0]         w_pick_gnt;
  logic                 w_pick_valid;
  logic [c_IW-1:0]      w_pick_idx;
  arb_cmd_t             w_pick_cmd;
  logic                 w_grant;
  logic                 w_rd_cpl;
  logic                 w_wr_cpl;
  logic                 w_cpl;
  logic                 w_tmo;

  rr_pick #(
    .N  (N),
    .IW (c_IW)
  ) u_rr_pick (
    .req_i   (rq_valid),
    .last_i  (last_q),
    .gnt_o   (w_pick_gnt),
    .valid_o (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    w_pick_cmd = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_gnt[i]) begin
        w_pick_idx         = c_IW'(i);
        w_pick_cmd.wr      = rq_wr[i];
        w_pick_cmd.byte_en = rq_byte[4*i +: 4];
        w_pick_cmd.addr    = rq_addr[4*i +: 4];
        w_pick_cmd.wdata   = rq_wdata[TL_DATA_W*i +: TL_DATA_W];
      end
    end
  end

  assign w_grant  = (state_q == IDLE) && m_trans_over && w_pick_valid;
  assign w_rd_cpl = !cmd_q.wr && m_rdata_v;
  // the master still reports the previous idle level in the first WAIT cycle
  assign w_wr_cpl = cmd_q.wr && m_trans_over && (timer_q != '0);
  assign w_cpl    = w_rd_cpl || w_wr_cpl;
  assign w_tmo    = (timer_q == c_TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_grant) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (w_cpl || w_tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    last_d     = last_q;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    m_wr_d     = 1'b0;
    m_rd_d     = 1'b0;
    rq_done_d  = '0;
    rq_err_d   = 1'b0;
    rq_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (w_grant) begin
          idx_d  = w_pick_idx;
          cmd_d  = w_pick_cmd;
          m_wr_d = w_pick_cmd.wr;
          m_rd_d = !w_pick_cmd.wr;
        end
      end
      ISSUE: begin
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (w_cpl || w_tmo) begin
          rq_done_d[idx_q] = 1'b1;
          rq_err_d         = !w_cpl;
          rq_rdata_d       = w_rd_cpl ? m_rdata : '0;
        end
      end
      DONE: begin
        last_d = idx_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      last_q     <= c_IW'(N - 1);
      cmd_q      <= '0;
      timer_q    <= '0;
      m_wr_q     <= 1'b0;
      m_rd_q     <= 1'b0;
      rq_done_q  <= '0;
      rq_err_q   <= 1'b0;
      rq_rdata_q <= '0;
    end else begin
      idx_q      <= idx_d;
      last_q     <= last_d;
      cmd_q      <= cmd_d;
      timer_q    <= timer_d;
      m_wr_q     <= m_wr_d;
      m_rd_q     <= m_rd_d;
      rq_done_q  <= rq_done_d;
      rq_err_q   <= rq_err_d;
      rq_rdata_q <= rq_rdata_d;
    end
  end

  assign m_wr     = m_wr_q;
  assign m_rd     = m_rd_q;
  assign m_byte   = cmd_q.byte_en;
  assign m_addr   = cmd_q.addr;
  assign m_wdata  = cmd_q.wdata;
  assign rq_done  = rq_done_q;
  assign rq_err   = rq_err_q;
  assign rq_rdata = rq_rdata_q;

endmodule

`default_nettype wire
